// File: rtl/button_debounce_if.sv
// Push-button conditioner signal bundle.
// master: the side that owns the raw button and consumes the conditioned outputs.
// slave:  the debouncer itself.
interface button_debounce_if;
  logic       btn_in;
  logic       level;
  logic       press_pulse;
  logic       release_pulse;
  logic       disp;
  logic [7:0] press_count;
  logic       long_pulse;

  modport master (
    output btn_in,
    input  level,
    input  press_pulse,
    input  release_pulse,
    input  disp,
    input  press_count,
    input  long_pulse
  );

  modport slave (
    input  btn_in,
    output level,
    output press_pulse,
    output release_pulse,
    output disp,
    output press_count,
    output long_pulse
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button debouncer feeding the LED blinker's disp input.
// The raw button is synchronised through two flops. A change is then accepted
// only after the synchronised level has differed from the accepted level for
// STABLE_TICKS consecutive cycles. Outputs: the clean level, one-cycle
// press/release strobes, a press-toggled disp, and an 8-bit wrapping press count.
// Optional long-press detection is compiled in with BUTTON_DEBOUNCE_LONGPRESS_EN.
// Without it, long_pulse is constant 0 and the FSM has no HELD state.
module button_debounce #(
  parameter int STABLE_TICKS = 16,
  parameter int LONG_TICKS   = 64,
  parameter int CNT_W        = 20
) (
  input logic             clock,
  input logic             reset,
  button_debounce_if.slave bus
);

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  typedef enum logic [1:0] {RELEASED = 2'd0, PRESSED = 2'd1, HELD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {RELEASED = 2'd0, PRESSED = 2'd1} state_t;
`endif

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS - 1);

  // Refuse to elaborate with a window too short to filter anything, or
  // counters too narrow to reach their thresholds.
  if (STABLE_TICKS < 2) begin : g_bad_stable
    $error("button_debounce: STABLE_TICKS must be at least 2");
  end
  if ((STABLE_TICKS >> CNT_W) != 0 || (LONG_TICKS >> CNT_W) != 0) begin : g_bad_width
    $error("button_debounce: CNT_W too narrow for STABLE_TICKS/LONG_TICKS");
  end

  logic [1:0]       sync_reg;
  logic             btn_sync;
  logic             differ;
  logic             accept;

  logic [CNT_W-1:0] stable_cnt_reg, stable_cnt_next;
  logic             level_reg,      level_next;
  logic             press_reg,      press_next;
  logic             release_reg,    release_next;
  logic             disp_reg,       disp_next;
  logic [7:0]       count_reg,      count_next;
  state_t           state_reg,      state_next;

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
  logic [CNT_W-1:0] hold_cnt_reg,   hold_cnt_next;
  logic             long_reg,       long_next;
`endif

  // Two-flop synchroniser; only the second stage is used downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], bus.btn_in};
    end
  end

  assign btn_sync = sync_reg[1];
  assign differ   = (btn_sync != level_reg);
  assign accept   = differ && (stable_cnt_reg == STABLE_LAST);

  // Next-state logic: stability window, strobes, toggle/count, and FSM.
  always_comb begin
    stable_cnt_next = stable_cnt_reg;
    level_next      = level_reg;
    press_next      = 1'b0;
    release_next    = 1'b0;
    disp_next       = disp_reg;
    count_next      = count_reg;
    state_next      = state_reg;
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    hold_cnt_next   = '0;
    long_next       = 1'b0;
`endif

    // Any cycle that agrees with the accepted level restarts the window.
    if (!differ || accept) begin
      stable_cnt_next = '0;
    end else begin
      stable_cnt_next = stable_cnt_reg + CNT_W'(1);
    end

    if (accept) begin
      level_next   = btn_sync;
      press_next   = btn_sync;
      release_next = ~btn_sync;
    end

    if (press_next) begin
      disp_next  = ~disp_reg;
      count_next = count_reg + 8'd1;
    end

    case (state_reg)
      RELEASED: begin
        if (press_next) begin
          state_next = PRESSED;
        end
      end
      PRESSED: begin
        if (release_next) begin
          state_next = RELEASED;
        end
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
        else if (hold_cnt_reg == LONG_LAST) begin
          state_next = HELD;
          long_next  = 1'b1;
        end
`endif
      end
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
      HELD: begin
        if (release_next) begin
          state_next = RELEASED;
        end
      end
`endif
      default: begin
        state_next = RELEASED;
      end
    endcase

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
    // Hold time only accumulates while staying in PRESSED; entry starts at 0.
    if (state_reg == PRESSED && state_next == PRESSED) begin
      hold_cnt_next = hold_cnt_reg + CNT_W'(1);
    end
`endif
  end

  // State register for everything behind the synchroniser.
  always_ff @(posedge clock) begin
    if (reset) begin
      stable_cnt_reg <= '0;
      level_reg      <= 1'b0;
      press_reg      <= 1'b0;
      release_reg    <= 1'b0;
      disp_reg       <= 1'b0;
      count_reg      <= 8'd0;
      state_reg      <= RELEASED;
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
      hold_cnt_reg   <= '0;
      long_reg       <= 1'b0;
`endif
    end else begin
      stable_cnt_reg <= stable_cnt_next;
      level_reg      <= level_next;
      press_reg      <= press_next;
      release_reg    <= release_next;
      disp_reg       <= disp_next;
      count_reg      <= count_next;
      state_reg      <= state_next;
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
      hold_cnt_reg   <= hold_cnt_next;
      long_reg       <= long_next;
`endif
    end
  end

  assign bus.level         = level_reg;
  assign bus.press_pulse   = press_reg;
  assign bus.release_pulse = release_reg;
  assign bus.disp          = disp_reg;
  assign bus.press_count   = count_reg;
`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  assign bus.long_pulse    = long_reg;
`else
  assign bus.long_pulse    = 1'b0;
`endif

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Upstream conditioning stage for the LED blinker's `disp` input.
- Takes a raw, bouncy, asynchronous push-button level and synchronises it into the `clock` domain.
- Rejects glitches shorter than a programmable stable window.
- Emits a clean debounced level, one-cycle press/release strobes, a toggle output that drives the blinker's `disp`, and a wrapping press counter.

Parameters:
- STABLE_TICKS, 16: consecutive cycles the synchronised input must differ from the accepted level before the change is accepted; must be ≥2.
- LONG_TICKS, 64: cycles the accepted level must stay high before a long-press is reported; used only with the optional feature.
- CNT_W, 20: width of the internal counters; must satisfy 2^CNT_W > max(STABLE_TICKS, LONG_TICKS).

Ports:
- clock, input, 1: system clock; all logic on posedge.
- reset, input, 1: synchronous, active-high reset.
- btn_in, input, 1: raw button level; asynchronous, may bounce.
- level, output, 1: debounced button level.
- press_pulse, output, 1: one-cycle strobe on accepted 0→1.
- release_pulse, output, 1: one-cycle strobe on accepted 1→0.
- disp, output, 1: toggles on every press_pulse; connects to the blinker's `disp` input.
- press_count, output, 8: number of accepted presses, mod 256.
- long_pulse, output, 1: one-cycle long-press strobe; tied to 0 unless the optional feature is enabled.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on posedge clock; reset has priority over all other logic.
- Reset values:
  - sync flops s1 and s2 = 0
  - stable counter = 0
  - level = 0
  - press_pulse, release_pulse, long_pulse = 0
  - disp = 0
  - press_count = 0
  - FSM state = RELEASED
  - hold counter = 0
- Synchroniser: two-flop chain btn_in→s1→s2. Only s2 (btn_sync) is used downstream. btn_in is never used combinationally.
- Stable counter, evaluated each edge:
  - If btn_sync == level: counter ← 0.
  - If btn_sync != level and counter == STABLE_TICKS−1: accept the change. level ← btn_sync, counter ← 0, and the matching strobe is set for one cycle.
  - Otherwise, if btn_sync != level: counter ← counter+1.
- Latency: edge N is the first edge sampling btn_in=1, and btn_in stays high thereafter. Then level and press_pulse rise on edge N+1+STABLE_TICKS, i.e. edge N+17 at default. Release timing is symmetric.
- Glitch rejection: any single cycle with btn_sync == level clears the counter. The full window must then be re-accumulated.
- Strobes: press_pulse and release_pulse are registered, high exactly one cycle, and mutually exclusive. They never assert outside an accepted transition.
- On the press_pulse edge:
  - disp ← ~disp
  - press_count ← press_count+1, wrapping 255→0 with no flag.
- FSM states: RELEASED, PRESSED, plus HELD with the optional feature.
  - RELEASED → PRESSED on accepted press.
  - PRESSED (or HELD) → RELEASED on accepted release.
- Reset mid-operation:
  - A partial count is discarded.
  - A button held through reset is treated as a new press after reset deasserts, with full sync + window latency.
  - disp returns to 0.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_LONGPRESS_EN.
- When defined:
  - The hold counter runs while state == PRESSED. It is cleared on entry to PRESSED and on any reset.
  - When the hold counter == LONG_TICKS−1: long_pulse is high for one cycle and state → HELD.
  - HELD produces no further long_pulse until a release and a new press.
  - The long_pulse edge = press_pulse edge + LONG_TICKS.
  - Release before the threshold produces no long_pulse.
- When undefined:
  - There is no HELD state and no hold counter.
  - long_pulse is constant 0.
  - All other behaviour is identical.

Test Plan (defaults: STABLE_TICKS=16, LONG_TICKS=64):
1. Reset for 3 cycles with btn_in=1 → all outputs 0 during reset. After deassert, press_pulse fires exactly 17 edges after the first post-reset sample; disp=1, press_count=1.
2. btn_in high for 10 cycles then low, repeated 5× → level, press_pulse, disp and press_count remain 0 throughout.
3. Bounce pattern 1,0,1,1,0 then steady 1 for 40 cycles, then steady 0 → exactly one press_pulse (17 edges after the steady-1 start) and exactly one release_pulse. Each strobe is 1 cycle wide.
4. 257 clean presses → disp toggles 257 times (ends at 1); press_count wraps to 1.
5. With BUTTON_DEBOUNCE_LONGPRESS_EN: hold for 200 cycles → one long_pulse exactly 64 edges after press_pulse, none after. Hold only 40 cycles → no long_pulse.
6. Assert reset at counter value 8 during a press window → no press_pulse. The counter restarts from 0 after reset deasserts.
